// File: rtl/axi_master_bridge_if.sv
// AXI4 bus bundle between axi_master_bridge (master modport) and a slave/testbench (slave modport).
interface axi_master_bridge_if;
  logic [3:0]  ARID_M;
  logic [31:0] ARADDR_M;
  logic [3:0]  ARLEN_M;
  logic [2:0]  ARSIZE_M;
  logic [1:0]  ARBURST_M;
  logic        ARVALID_M;
  logic        ARREADY_M;

  logic [3:0]  RID_M;
  logic [31:0] RDATA_M;
  logic [1:0]  RRESP_M;
  logic        RLAST_M;
  logic        RVALID_M;
  logic        RREADY_M;

  logic [3:0]  AWID_M;
  logic [31:0] AWADDR_M;
  logic [3:0]  AWLEN_M;
  logic [2:0]  AWSIZE_M;
  logic [1:0]  AWBURST_M;
  logic        AWVALID_M;
  logic        AWREADY_M;

  logic [31:0] WDATA_M;
  logic [3:0]  WSTRB_M;
  logic        WLAST_M;
  logic        WVALID_M;
  logic        WREADY_M;

  logic [3:0]  BID_M;
  logic [1:0]  BRESP_M;
  logic        BVALID_M;
  logic        BREADY_M;

  modport master (
    output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    input  ARREADY_M,
    input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    output RREADY_M,
    output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    input  AWREADY_M,
    output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    input  WREADY_M,
    input  BID_M, BRESP_M, BVALID_M,
    output BREADY_M
  );

  modport slave (
    input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
    output ARREADY_M,
    output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
    input  RREADY_M,
    input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
    output AWREADY_M,
    input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
    output WREADY_M,
    output BID_M, BRESP_M, BVALID_M,
    input  BREADY_M
  );
endinterface

// File: rtl/axi_master_bridge.sv
// Single-outstanding core-to-AXI4 master bridge: one read (optionally burst) or one single-beat write at a time.
// Define AXI_MASTER_BURST_EN to enable multi-beat read bursts driven by core_len.
module axi_master_bridge #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  input  logic                       core_req,
  input  logic                       core_write,
  input  logic [31:0]                core_addr,
  input  logic [31:0]                core_wdata,
  input  logic [3:0]                 core_wstrb,
  input  logic [3:0]                 core_len,
  output logic                       core_busy,
  output logic                       core_done,
  output logic                       core_err,
  output logic [31:0]                core_rdata,
  output logic                       core_rvalid,
  axi_master_bridge_if.master        axi
);

  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP} state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        arValid_q;
  logic        rReady_q;
  logic        awValid_q;
  logic        wValid_q;
  logic        bReady_q;
  logic        awOk_q;
  logic        wOk_q;
  logic        err_q;

  logic arHs, rHs, awHs, wHs, bHs;
  logic rFinal, rErr, bErr, lastErr;
  logic unused_ids;

  assign arHs = arValid_q & axi.ARREADY_M;
  assign rHs  = rReady_q  & axi.RVALID_M;
  assign awHs = awValid_q & axi.AWREADY_M;
  assign wHs  = wValid_q  & axi.WREADY_M;
  assign bHs  = bReady_q  & axi.BVALID_M;
  assign rErr = rHs & (axi.RRESP_M != 2'b00);
  assign bErr = bHs & (axi.BRESP_M != 2'b00);

`ifdef AXI_MASTER_BURST_EN
  logic [3:0] len_q;
  logic [3:0] beatCnt_q;

  // RLAST must coincide with the counter reaching ARLEN; any disagreement flags an error.
  assign rFinal      = rHs & axi.RLAST_M;
  assign lastErr     = rHs & (axi.RLAST_M != (beatCnt_q == len_q));
  assign axi.ARLEN_M = len_q;
  assign unused_ids  = ^{axi.RID_M, axi.BID_M};
`else
  assign rFinal      = rHs;
  assign lastErr     = 1'b0;
  assign axi.ARLEN_M = 4'd0;
  assign unused_ids  = ^{axi.RID_M, axi.BID_M, axi.RLAST_M, core_len};
`endif

  assign axi.ARID_M    = MASTER_ID;
  assign axi.ARADDR_M  = addr_q;
  assign axi.ARSIZE_M  = 3'b010;
  assign axi.ARBURST_M = 2'b01;
  assign axi.ARVALID_M = arValid_q;
  assign axi.RREADY_M  = rReady_q;
  assign axi.AWID_M    = MASTER_ID;
  assign axi.AWADDR_M  = addr_q;
  assign axi.AWLEN_M   = 4'd0;
  assign axi.AWSIZE_M  = 3'b010;
  assign axi.AWBURST_M = 2'b01;
  assign axi.AWVALID_M = awValid_q;
  assign axi.WDATA_M   = wdata_q;
  assign axi.WSTRB_M   = wstrb_q;
  assign axi.WLAST_M   = 1'b1;
  assign axi.WVALID_M  = wValid_q;
  assign axi.BREADY_M  = bReady_q;

  assign core_busy   = (state_q != IDLE);
  assign core_done   = rFinal | bHs;
  assign core_err    = core_done & (err_q | rErr | bErr | lastErr);
  assign core_rvalid = rHs;
  assign core_rdata  = axi.RDATA_M;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      arValid_q <= 1'b0;
      rReady_q  <= 1'b0;
      awValid_q <= 1'b0;
      wValid_q  <= 1'b0;
      bReady_q  <= 1'b0;
      awOk_q    <= 1'b0;
      wOk_q     <= 1'b0;
      err_q     <= 1'b0;
`ifdef AXI_MASTER_BURST_EN
      len_q     <= 4'd0;
      beatCnt_q <= 4'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (core_req) begin
            addr_q  <= core_addr;
            wdata_q <= core_wdata;
            wstrb_q <= core_wstrb;
            err_q   <= 1'b0;
            awOk_q  <= 1'b0;
            wOk_q   <= 1'b0;
`ifdef AXI_MASTER_BURST_EN
            len_q     <= core_len;
            beatCnt_q <= 4'd0;
`endif
            if (core_write) begin
              state_q   <= WADDR;
              awValid_q <= 1'b1;
              wValid_q  <= 1'b1;
            end else begin
              state_q   <= RADDR;
              arValid_q <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (arHs) begin
            arValid_q <= 1'b0;
            rReady_q  <= 1'b1;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (rHs) begin
            err_q <= err_q | rErr | lastErr;
`ifdef AXI_MASTER_BURST_EN
            beatCnt_q <= beatCnt_q + 4'd1;
`endif
          end
          if (rFinal) begin
            rReady_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        WADDR: begin
          if (awHs) begin
            awValid_q <= 1'b0;
            awOk_q    <= 1'b1;
          end
          if (wHs) begin
            wValid_q <= 1'b0;
            wOk_q    <= 1'b1;
          end
          // Move on once both channels have completed, whether together or one after the other.
          if ((awOk_q | awHs) && (wOk_q | wHs)) begin
            bReady_q <= 1'b1;
            state_q  <= WRESP;
          end
        end
        WRESP: begin
          if (bHs) begin
            bReady_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed self-checking bench for axi_master_bridge; burst steps run only when AXI_MASTER_BURST_EN is defined.
module tb_axi_master_bridge;

  logic        ACLK;
  logic        ARESETn;
  logic        core_req;
  logic        core_write;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic [3:0]  core_len;
  logic        core_busy;
  logic        core_done;
  logic        core_err;
  logic [31:0] core_rdata;
  logic        core_rvalid;

  int vecCount;
  int missCount;

  axi_master_bridge_if axi ();

  axi_master_bridge #(.MASTER_ID(4'd0)) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .core_req    (core_req),
    .core_write  (core_write),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_wstrb  (core_wstrb),
    .core_len    (core_len),
    .core_busy   (core_busy),
    .core_done   (core_done),
    .core_err    (core_err),
    .core_rdata  (core_rdata),
    .core_rvalid (core_rvalid),
    .axi         (axi.master)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb, input logic [3:0] len);
    core_req   = req;
    core_write = wr;
    core_addr  = addr;
    core_wdata = wdata;
    core_wstrb = wstrb;
    core_len   = len;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    assert (observed === expected)
      else begin
        missCount++;
        $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
  endtask

  initial begin
    vecCount  = 0;
    missCount = 0;
    ARESETn   = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0);
    axi.ARREADY_M = 1'b0;
    axi.RID_M     = 4'hA;
    axi.RDATA_M   = 32'h0;
    axi.RRESP_M   = 2'b00;
    axi.RLAST_M   = 1'b0;
    axi.RVALID_M  = 1'b0;
    axi.AWREADY_M = 1'b0;
    axi.WREADY_M  = 1'b0;
    axi.BID_M     = 4'h3;
    axi.BRESP_M   = 2'b00;
    axi.BVALID_M  = 1'b0;

    #12;
    checkOutput("rst_busy",    core_busy,      0);
    checkOutput("rst_done",    core_done,      0);
    checkOutput("rst_err",     core_err,       0);
    checkOutput("rst_rvalid",  core_rvalid,    0);
    checkOutput("rst_arvalid", axi.ARVALID_M,  0);
    checkOutput("rst_awvalid", axi.AWVALID_M,  0);
    checkOutput("rst_wvalid",  axi.WVALID_M,   0);
    checkOutput("rst_rready",  axi.RREADY_M,   0);
    checkOutput("rst_bready",  axi.BREADY_M,   0);
    checkOutput("rst_araddr",  axi.ARADDR_M,   0);
    checkOutput("rst_wdata",   axi.WDATA_M,    0);
    checkOutput("rst_wstrb",   axi.WSTRB_M,    0);
    checkOutput("rst_arlen",   axi.ARLEN_M,    0);
    ARESETn = 1'b1;

    // Read at 0x1000 with ARREADY on the third address cycle
    applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 4'h0);
    tick();
    core_req = 1'b0;
    checkOutput("rd1_busy",    core_busy,     1);
    checkOutput("rd1_araddr",  axi.ARADDR_M,  32'h0000_1000);
    checkOutput("rd1_arlen",   axi.ARLEN_M,   0);
    checkOutput("rd1_arsize",  axi.ARSIZE_M,  3'b010);
    checkOutput("rd1_arburst", axi.ARBURST_M, 2'b01);
    checkOutput("rd1_arid",    axi.ARID_M,    0);
    checkOutput("rd1_arv_c1",  axi.ARVALID_M, 1);
    checkOutput("rd1_done_c1", core_done,     0);
    tick();
    checkOutput("rd1_arv_c2",  axi.ARVALID_M, 1);
    tick();
    axi.ARREADY_M = 1'b1;
    #1;
    checkOutput("rd1_arv_c3",  axi.ARVALID_M, 1);
    checkOutput("rd1_rready0", axi.RREADY_M,  0);
    tick();
    axi.ARREADY_M = 1'b0;
    checkOutput("rd1_arv_drop", axi.ARVALID_M, 0);
    checkOutput("rd1_rready",   axi.RREADY_M,  1);
    checkOutput("rd1_rv_idle",  core_rvalid,   0);
    axi.RVALID_M = 1'b1;
    axi.RDATA_M  = 32'hCAFE_0001;
    axi.RLAST_M  = 1'b1;
    #1;
    checkOutput("rd1_rvalid", core_rvalid, 1);
    checkOutput("rd1_rdata",  core_rdata,  32'hCAFE_0001);
    checkOutput("rd1_done",   core_done,   1);
    checkOutput("rd1_err",    core_err,    0);
    tick();
    axi.RVALID_M = 1'b0;
    axi.RLAST_M  = 1'b0;
    checkOutput("rd1_idle_busy", core_busy, 0);
    checkOutput("rd1_idle_done", core_done, 0);

    // Write with W handshake two cycles before AW, then B OKAY
    applyStimulus(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 4'h0);
    tick();
    core_req = 1'b0;
    checkOutput("wr1_awvalid", axi.AWVALID_M, 1);
    checkOutput("wr1_wvalid",  axi.WVALID_M,  1);
    checkOutput("wr1_awaddr",  axi.AWADDR_M,  32'h0000_2000);
    checkOutput("wr1_wdata",   axi.WDATA_M,   32'hDEAD_BEEF);
    checkOutput("wr1_wstrb",   axi.WSTRB_M,   4'b0011);
    checkOutput("wr1_wlast",   axi.WLAST_M,   1);
    checkOutput("wr1_awlen",   axi.AWLEN_M,   0);
    axi.WREADY_M = 1'b1;
    tick();
    axi.WREADY_M = 1'b0;
    checkOutput("wr1_wv_drop", axi.WVALID_M,  0);
    checkOutput("wr1_awv_c2",  axi.AWVALID_M, 1);
    tick();
    checkOutput("wr1_awv_c3",  axi.AWVALID_M, 1);
    checkOutput("wr1_bready0", axi.BREADY_M,  0);
    axi.AWREADY_M = 1'b1;
    tick();
    axi.AWREADY_M = 1'b0;
    checkOutput("wr1_awv_drop", axi.AWVALID_M, 0);
    checkOutput("wr1_bready",   axi.BREADY_M,  1);
    checkOutput("wr1_busy",     core_busy,     1);
    axi.BVALID_M = 1'b1;
    axi.BRESP_M  = 2'b00;
    core_req     = 1'b1;
    #1;
    checkOutput("wr1_done", core_done, 1);
    checkOutput("wr1_err",  core_err,  0);
    tick();
    axi.BVALID_M = 1'b0;
    checkOutput("wr1_req_ignored", core_busy, 0);
    core_req = 1'b0;

    // Write with AW and W accepted together, then SLVERR response
    applyStimulus(1'b1, 1'b1, 32'h0000_3000, 32'h1234_5678, 4'hF, 4'h0);
    tick();
    core_req      = 1'b0;
    axi.AWREADY_M = 1'b1;
    axi.WREADY_M  = 1'b1;
    tick();
    axi.AWREADY_M = 1'b0;
    axi.WREADY_M  = 1'b0;
    checkOutput("wr2_bready",  axi.BREADY_M,  1);
    checkOutput("wr2_awvalid", axi.AWVALID_M, 0);
    checkOutput("wr2_wvalid",  axi.WVALID_M,  0);
    axi.BVALID_M = 1'b1;
    axi.BRESP_M  = 2'b10;
    #1;
    checkOutput("wr2_done", core_done, 1);
    checkOutput("wr2_err",  core_err,  1);
    tick();
    axi.BVALID_M = 1'b0;
    axi.BRESP_M  = 2'b00;
    checkOutput("wr2_after_done", core_done, 0);
    checkOutput("wr2_after_err",  core_err,  0);

`ifdef AXI_MASTER_BURST_EN
    // Four-beat burst with a gap before every beat
    applyStimulus(1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 4'd3);
    tick();
    core_req = 1'b0;
    checkOutput("bst1_arlen", axi.ARLEN_M, 4'd3);
    axi.ARREADY_M = 1'b1;
    tick();
    axi.ARREADY_M = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi.RVALID_M = 1'b0;
      #1;
      checkOutput("bst1_gap_rvalid", core_rvalid, 0);
      tick();
      axi.RVALID_M = 1'b1;
      axi.RDATA_M  = 32'hB000_0000 + 32'(i);
      axi.RLAST_M  = (i == 3);
      #1;
      checkOutput("bst1_rvalid", core_rvalid, 1);
      checkOutput("bst1_rdata",  core_rdata,  32'hB000_0000 + 32'(i));
      checkOutput("bst1_done",   core_done,   (i == 3) ? 32'd1 : 32'd0);
      checkOutput("bst1_err",    core_err,    0);
      tick();
    end
    axi.RVALID_M = 1'b0;
    axi.RLAST_M  = 1'b0;
    checkOutput("bst1_idle", core_busy, 0);

    // Same burst length but RLAST arrives early on the third beat
    applyStimulus(1'b1, 1'b0, 32'h0000_5100, 32'h0, 4'h0, 4'd3);
    tick();
    core_req      = 1'b0;
    axi.ARREADY_M = 1'b1;
    tick();
    axi.ARREADY_M = 1'b0;
    for (int i = 0; i < 3; i++) begin
      axi.RVALID_M = 1'b1;
      axi.RDATA_M  = 32'hC000_0000 + 32'(i);
      axi.RLAST_M  = (i == 2);
      #1;
      checkOutput("bst2_done", core_done, (i == 2) ? 32'd1 : 32'd0);
      checkOutput("bst2_err",  core_err,  (i == 2) ? 32'd1 : 32'd0);
      tick();
    end
    axi.RVALID_M = 1'b0;
    axi.RLAST_M  = 1'b0;
    checkOutput("bst2_idle", core_busy, 0);
`else
    // Without bursts core_len is ignored and the first beat ends the read even without RLAST
    applyStimulus(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 4'd5);
    tick();
    core_req = 1'b0;
    checkOutput("rd2_arlen", axi.ARLEN_M, 0);
    axi.ARREADY_M = 1'b1;
    tick();
    axi.ARREADY_M = 1'b0;
    axi.RVALID_M  = 1'b1;
    axi.RDATA_M   = 32'h4444_0000;
    axi.RLAST_M   = 1'b0;
    axi.RRESP_M   = 2'b11;
    #1;
    checkOutput("rd2_done", core_done, 1);
    checkOutput("rd2_err",  core_err,  1);
    tick();
    axi.RVALID_M = 1'b0;
    axi.RRESP_M  = 2'b00;
    checkOutput("rd2_idle", core_busy, 0);
`endif

    // Reset asserted while waiting for read data abandons the read
    applyStimulus(1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'h0, 4'd3);
    tick();
    core_req      = 1'b0;
    axi.ARREADY_M = 1'b1;
    tick();
    axi.ARREADY_M = 1'b0;
`ifdef AXI_MASTER_BURST_EN
    axi.RVALID_M = 1'b1;
    axi.RDATA_M  = 32'h6666_0000;
    axi.RLAST_M  = 1'b0;
    tick();
`endif
    checkOutput("rst_mid_rready_pre", axi.RREADY_M, 1);
    axi.RVALID_M = 1'b1;
    axi.RLAST_M  = 1'b1;
    ARESETn      = 1'b0;
    #1;
    checkOutput("rst_mid_busy",   core_busy,    0);
    checkOutput("rst_mid_rready", axi.RREADY_M, 0);
    checkOutput("rst_mid_done",   core_done,    0);
    checkOutput("rst_mid_rvalid", core_rvalid,  0);
    checkOutput("rst_mid_araddr", axi.ARADDR_M, 0);
    tick();
    checkOutput("rst_mid_done2",  core_done,    0);
    axi.RVALID_M = 1'b0;
    axi.RLAST_M  = 1'b0;
    ARESETn      = 1'b1;

    applyStimulus(1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'h0, 4'h0);
    tick();
    core_req = 1'b0;
    checkOutput("post_rst_araddr",  axi.ARADDR_M,  32'h0000_7000);
    checkOutput("post_rst_arvalid", axi.ARVALID_M, 1);
    axi.ARREADY_M = 1'b1;
    tick();
    axi.ARREADY_M = 1'b0;
    axi.RVALID_M  = 1'b1;
    axi.RDATA_M   = 32'h7777_0077;
    axi.RLAST_M   = 1'b1;
    #1;
    checkOutput("post_rst_rdata", core_rdata, 32'h7777_0077);
    checkOutput("post_rst_done",  core_done,  1);
    checkOutput("post_rst_err",   core_err,   0);
    tick();
    axi.RVALID_M = 1'b0;
    axi.RLAST_M  = 1'b0;
    checkOutput("post_rst_idle", core_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/axi_master_bridge.md
AXI_MASTER_BRIDGE -- requirements
Module: axi_master_bridge

Interface
REQ-001 Param MASTER_ID, default 4'd0, constant driven on ARID_M/AWID_M.
REQ-002 ACLK  in  1  single clock; all logic on posedge.
REQ-003 ARESETn  in  1  asynchronous, active-low reset.
REQ-004 core_req/core_write  in  1/1  request strobe (sampled in IDLE); 1=write, 0=read.
REQ-005 core_addr/core_wdata/core_wstrb/core_len  in  32/32/4/4  byte address; write data; byte enables; read beats-1.
REQ-006 core_busy/core_done/core_err  out  1/1/1  state!=IDLE; final-handshake pulse; error, valid with core_done.
REQ-007 core_rdata/core_rvalid  out  32/1  read beat data; beat strobe.
REQ-008 AR: ARID_M 4, ARADDR_M 32, ARLEN_M 4, ARSIZE_M 3, ARBURST_M 2, ARVALID_M out; ARREADY_M in.
REQ-009 R: RID_M 4, RDATA_M 32, RRESP_M 2, RLAST_M 1, RVALID_M in; RREADY_M out.
REQ-010 AW: AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M out (widths as AR); AWREADY_M in.
REQ-011 W: WDATA_M 32, WSTRB_M 4, WLAST_M 1, WVALID_M out; WREADY_M in.
REQ-012 B: BID_M 4, BRESP_M 2, BVALID_M in; BREADY_M out.

Function
REQ-013 States IDLE, RADDR, RDATA, WADDR (AW+W concurrent), WRESP; encoding free.
REQ-014 IDLE & core_req -> latch addr/wdata/wstrb/len next edge; core_write=1 -> WADDR, else RADDR; no other IDLE exit.
REQ-015 ARSIZE_M=AWSIZE_M=3'b010, ARBURST_M=AWBURST_M=2'b01 (INCR), AWLEN_M=0, WLAST_M=1, address driven from latched copy.
REQ-016 VALID asserted from state entry, held stable with payload until READY; never withdrawn before handshake.
REQ-017 RADDR: ARVALID_M=1; AR handshake -> RDATA.
REQ-018 RDATA: RREADY_M=1; core_rdata=RDATA_M, core_rvalid=RVALID_M&RREADY_M (combinational, zero latency).
REQ-019 RDATA exit on final beat handshake (REQ-033/034) -> IDLE; core_done=1 that cycle.
REQ-020 WADDR: AWVALID_M and WVALID_M both asserted on entry; sticky flags aw_ok/w_ok record each handshake.
REQ-021 Each channel's VALID drops the cycle after its own handshake; other keeps VALID until its handshake.
REQ-022 Simultaneous AW and W handshake same cycle -> WRESP next edge; otherwise WRESP after the later one.
REQ-023 WRESP: BREADY_M=1; B handshake -> IDLE, core_done=1 that cycle.
REQ-024 core_err=1 with core_done if any RRESP_M/BRESP_M of the transaction != 2'b00; sticky error flag cleared on IDLE exit.
REQ-025 RID_M/BID_M not checked; any ID accepted.
REQ-026 Minimum one IDLE cycle between transactions; core_req high during core_done is ignored.
REQ-027 core_busy=1 in every non-IDLE state; core_done, core_rvalid 0 outside listed cycles.

Reset
REQ-028 ARESETn low -> IDLE immediately; all VALID/READY outputs, core_done, core_err, core_busy, core_rvalid =0.
REQ-029 Latched addr/data/len/flags/beat counter reset to 0; ARADDR_M/AWADDR_M/WDATA_M/WSTRB_M/ARLEN_M read 0 after reset.
REQ-030 Reset mid-transaction abandons it without core_done; no outstanding-transaction recovery.
REQ-031 First core_req accepted on first posedge after ARESETn deasserts.

Configuration
REQ-032 Macro AXI_MASTER_BURST_EN selects read-burst support.
REQ-033 Defined: ARLEN_M=latched core_len; 4-bit beat counter increments per R handshake, clears on IDLE exit; final beat = RLAST_M handshake; core_err also set if RLAST_M position != counter==ARLEN_M.
REQ-034 Undefined: ARLEN_M=0, core_len ignored, no counter; first R handshake is final regardless of RLAST_M.

Verification
REQ-035 Read, core_addr=0x0000_1000, ARREADY_M after 3 cycles -> ARVALID_M held 3 cycles, ARADDR_M=0x1000, ARLEN_M=0, one core_rvalid, core_done, core_err=0.
REQ-036 Write wdata=0xDEAD_BEEF, wstrb=4'b0011, WREADY 2 cycles before AWREADY -> WVALID drops after W handshake, AWVALID held, B OKAY -> core_done, err=0.
REQ-037 Write, AWREADY_M=WREADY_M=1 same cycle -> WRESP next cycle; BRESP_M=2'b10 -> core_done with core_err=1.
REQ-038 (BURST_EN) Read core_len=3, RVALID gapped -> four core_rvalid pulses, RLAST on 4th, core_done on 4th; RLAST on 3rd instead -> core_done with core_err=1.
REQ-039 ARESETn low during RDATA after 1 of 4 beats -> all outputs 0 same cycle, no core_done; new read after release completes normally.
